bus_rr_arbiter: RTL and testbench

- Shares one bus device (e.g. the RAM behind the compliance bus) between NrHosts requesters using round-robin grant.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the host that issued it.
- Sits between host ports (core I/D, test utility) and a single device port.
- Replaces the fixed-priority selection for that device.

---
 rtl/bus_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one bus device among NrHosts hosts, with in-order response routing.
// Optional burst lock (up to 4 consecutive grants to one host) enabled by BUS_RR_ARBITER_LOCK_EN.
module bus_rr_arbiter #(
  parameter int unsigned NrHosts        = 3,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NrHosts-1:0]                      host_req_i,
  output logic [NrHosts-1:0]                      host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]                      host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
  output logic [NrHosts-1:0]                      host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
  output logic [NrHosts-1:0]                      host_err_o,
  output logic                                    device_req_o,
  input  logic                                    device_gnt_i,
  output logic [AddressWidth-1:0]                 device_addr_o,
  output logic                                    device_we_o,
  output logic [DataWidth/8-1:0]                  device_be_o,
  output logic [DataWidth-1:0]                    device_wdata_o,
  input  logic                                    device_rvalid_i,
  input  logic [DataWidth-1:0]                    device_rdata_i,
  input  logic                                    device_err_i,
  output logic                                    protocol_err_o
);

  localparam int unsigned HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  logic [HostW-1:0] rr_ptr_q, rr_ptr_d;
  logic [HostW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             perr_q, perr_d;

  logic [HostW-1:0] winner;
  logic [HostW-1:0] head;
  logic             any_req, full, empty, dev_req, push, pop;
  int unsigned      idx;

  function automatic logic [HostW-1:0] next_host(input logic [HostW-1:0] h);
    return (h == HostW'(NrHosts - 1)) ? '0 : HostW'(h + HostW'(1));
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : PtrW'(p + PtrW'(1));
  endfunction

  // First requester at or after rr_ptr, wrapping modulo NrHosts.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      idx = (32'(rr_ptr_q) + i) % NrHosts;
      if (!any_req && host_req_i[idx]) begin
        any_req = 1'b1;
        winner  = HostW'(idx);
      end
    end
  end

  assign full    = (count_q == CntW'(MaxOutstanding));
  assign empty   = (count_q == '0);
  assign head    = fifo_q[rd_ptr_q];
  assign dev_req = any_req && !full && !rst_i;
  assign push    = dev_req && device_gnt_i;
  assign pop     = device_rvalid_i && !empty && !rst_i;

  assign device_req_o   = dev_req;
  assign device_addr_o  = dev_req ? host_addr_i[winner]  : '0;
  assign device_we_o    = dev_req ? host_we_i[winner]    : 1'b0;
  assign device_be_o    = dev_req ? host_be_i[winner]    : '0;
  assign device_wdata_o = dev_req ? host_wdata_i[winner] : '0;

  assign host_gnt_o     = push ? (NrHosts'(1) << winner) : '0;
  assign host_rvalid_o  = pop ? (NrHosts'(1) << head) : '0;
  assign host_err_o     = (pop && device_err_i) ? (NrHosts'(1) << head) : '0;
  assign host_rdata_o   = {NrHosts{device_rdata_i}};
  assign protocol_err_o = perr_q;

  // Response-routing FIFO bookkeeping and sticky protocol error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    perr_d   = perr_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = CntW'(count_q + CntW'(1));
      2'b01:   count_d = CntW'(count_q - CntW'(1));
      default: count_d = count_q;
    endcase
    if (device_rvalid_i && empty) perr_d = 1'b1;
  end

`ifdef BUS_RR_ARBITER_LOCK_EN
  logic [1:0] lock_cnt_q, lock_cnt_d;

  // Hold the pointer on a locked host until it drops its request or takes 4 grants in a row.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    if (push) begin
      if (winner == rr_ptr_q && lock_cnt_q != 2'd0) begin
        if (lock_cnt_q == 2'd3) begin
          rr_ptr_d   = next_host(winner);
          lock_cnt_d = 2'd0;
        end else begin
          lock_cnt_d = 2'(lock_cnt_q + 2'd1);
        end
      end else begin
        rr_ptr_d   = winner;
        lock_cnt_d = 2'd1;
      end
    end else if (lock_cnt_q != 2'd0 && !host_req_i[rr_ptr_q]) begin
      rr_ptr_d   = next_host(rr_ptr_q);
      lock_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_cnt_q <= 2'd0;
    else       lock_cnt_q <= lock_cnt_d;
  end
`else
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = next_host(winner);
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      perr_q   <= 1'b0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      perr_q   <= perr_d;
      if (push) fifo_q[wr_ptr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: per-cycle directed stimulus with a response-routing scoreboard.
module tb_bus_rr_arbiter;

  localparam int unsigned N = 3;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [N-1:0]         host_req_i = '0;
  logic [N-1:0]         host_gnt_o;
  logic [N-1:0][31:0]   host_addr_i;
  logic [N-1:0]         host_we_i = 3'b101;
  logic [N-1:0][3:0]    host_be_i;
  logic [N-1:0][31:0]   host_wdata_i;
  logic [N-1:0]         host_rvalid_o;
  logic [N-1:0][31:0]   host_rdata_o;
  logic [N-1:0]         host_err_o;
  logic                 device_req_o;
  logic                 device_gnt_i = 1'b0;
  logic [31:0]          device_addr_o;
  logic                 device_we_o;
  logic [3:0]           device_be_o;
  logic [31:0]          device_wdata_o;
  logic                 device_rvalid_i = 1'b0;
  logic [31:0]          device_rdata_i = '0;
  logic                 device_err_i = 1'b0;
  logic                 protocol_err_o;

  int n_checks = 0;
  int n_errors = 0;
  int resp_q[$];
  logic exp_perr = 1'b0;

  bus_rr_arbiter #(.NrHosts(N), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_gnt_i(device_gnt_i), .device_addr_o(device_addr_o),
    .device_we_o(device_we_o), .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i), .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, sample mid-cycle, score, then advance past the edge.
  task automatic cycle(input logic [N-1:0] req, input logic dgnt, input int exp_w,
                       input logic rv, input logic [31:0] rd, input logic er, input logic exp_dreq);
    logic [N-1:0] exp_gnt, exp_rv, exp_err;
    logic set_perr;
    int h;
    host_req_i = req; device_gnt_i = dgnt;
    device_rvalid_i = rv; device_rdata_i = rd; device_err_i = er;
    #2;
    exp_gnt = (exp_w >= 0 && dgnt) ? N'(1) << exp_w : '0;
    exp_rv = '0; exp_err = '0; set_perr = 1'b0;
    check("device_req", 64'(device_req_o), 64'(exp_dreq));
    check("host_gnt", 64'(host_gnt_o), 64'(exp_gnt));
    if (exp_dreq && exp_w >= 0) begin
      check("device_addr", 64'(device_addr_o), 64'(host_addr_i[exp_w]));
      check("device_we", 64'(device_we_o), 64'(host_we_i[exp_w]));
      check("device_be", 64'(device_be_o), 64'(host_be_i[exp_w]));
      check("device_wdata", 64'(device_wdata_o), 64'(host_wdata_i[exp_w]));
    end else begin
      check("device_addr_idle", 64'(device_addr_o), 64'd0);
    end
    if (rv) begin
      if (resp_q.size() > 0) begin
        h = resp_q.pop_front();
        exp_rv = N'(1) << h;
        exp_err = er ? N'(1) << h : '0;
      end else begin
        set_perr = 1'b1;
      end
      check("rdata0", 64'(host_rdata_o[0]), 64'(rd));
      check("rdata2", 64'(host_rdata_o[N-1]), 64'(rd));
    end
    check("host_rvalid", 64'(host_rvalid_o), 64'(exp_rv));
    check("host_err", 64'(host_err_o), 64'(exp_err));
    check("protocol_err", 64'(protocol_err_o), 64'(exp_perr));
    if (exp_gnt != '0) resp_q.push_back(exp_w);
    @(posedge clk_i); #1;
    if (set_perr) exp_perr = 1'b1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; host_req_i = '1; device_gnt_i = 1'b1; device_rvalid_i = 1'b1;
    #1;
    check("rst_device_req", 64'(device_req_o), 64'd0);
    check("rst_gnt", 64'(host_gnt_o), 64'd0);
    check("rst_rvalid", 64'(host_rvalid_o), 64'd0);
    check("rst_err", 64'(host_err_o), 64'd0);
    check("rst_protocol_err", 64'(protocol_err_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; host_req_i = '0; device_gnt_i = 1'b0; device_rvalid_i = 1'b0;
    resp_q.delete();
    exp_perr = 1'b0;
  endtask

`ifdef BUS_RR_ARBITER_LOCK_EN
  int ord[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
  int ord[6] = '{0, 1, 2, 0, 1, 2};
`endif

  initial begin
    for (int h = 0; h < N; h++) begin
      host_addr_i[h]  = 32'h100 + 32'(h) * 32'h10;
      host_be_i[h]    = 4'(1 << h);
      host_wdata_i[h] = 32'hA000_0000 + 32'(h);
    end
    #3;
    do_reset();

    // Single host, response next cycle.
    cycle(3'b001, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, -1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);

    // All hosts requesting continuously.
    do_reset();
    foreach (ord[i])
      cycle(3'b111, 1'b1, ord[i], i > 0, 32'hC000 + 32'(i), 1'b0, 1'b1);
    cycle(3'b000, 1'b0, -1, 1'b1, 32'hC0FF, 1'b0, 1'b0);

    // FIFO fills, no full-bypass on pop, re-issue after pop.
    do_reset();
    cycle(3'b001, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(3'b001, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(3'b001, 1'b1, -1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(3'b001, 1'b1, -1, 1'b1, 32'h1111, 1'b0, 1'b0);
    cycle(3'b001, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, -1, 1'b1, 32'h2222, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, -1, 1'b1, 32'h3333, 1'b0, 1'b0);

    // Error routed to the issuing host.
    do_reset();
    cycle(3'b010, 1'b1, 1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(3'b100, 1'b1, 2, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, -1, 1'b1, 32'h4444, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, -1, 1'b1, 32'h5555, 1'b1, 1'b0);

    // Response with nothing outstanding is sticky until reset.
    do_reset();
    cycle(3'b000, 1'b0, -1, 1'b1, 32'h6666, 1'b1, 1'b0);
    cycle(3'b000, 1'b0, -1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, -1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("perr_sticky", 64'(exp_perr), 64'd1);

    // Reset with two outstanding; stale response afterwards.
    do_reset();
    cycle(3'b001, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(3'b010, 1'b1, 1, 1'b0, 32'h0, 1'b0, 1'b1);
    do_reset();
    cycle(3'b000, 1'b0, -1, 1'b1, 32'h7777, 1'b0, 1'b0);
    cycle(3'b001, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, -1, 1'b1, 32'h8888, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, -1, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
